// File: rtl/lc3_ctrl_pkg.sv
// Shared state encoding and control-field encodings for the LC-3 sequencer.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED, S_FETCH, S_RD_F, S_IR_LD, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR_TAKE, S_JMP, S_JSR_R7, S_JSR_OFF,
        S_MAR_BASE, S_MAR_PC, S_RD_D, S_LD_WB, S_ST_MDR, S_WR_D,
        S_LEA, S_PAUSE, S_PAUSE1, S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;
    localparam logic [3:0] OP_LEA   = 4'b1110;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    // States that hold a memory strobe and share the wait timer.
    function automatic logic is_mem_access(input state_t s);
        return (s == S_RD_F) || (s == S_RD_D) || (s == S_WR_D);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state timer shared by the fetch read, data read and data write accesses.
// Either counts a fixed number of cycles or follows the memory ready handshake.
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT = 2,
    parameter bit          USE_RDY  = 1'b0
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic start,
    input  logic busy,
    input  logic Mem_Rdy,
    output logic last,
    output logic done
);

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

    logic [2:0] wait_cnt;

    // Preload on access entry, then count down to zero while the access runs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wait_cnt <= 3'd0;
        end else if (start) begin
            wait_cnt <= USE_RDY ? 3'd0 : WAIT_LOAD;
        end else if (busy && (wait_cnt != 3'd0)) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // The access ends on the cycle the counter is zero, or when memory says ready.
    always_comb begin
        done = USE_RDY ? Mem_Rdy : (wait_cnt == 3'd0);
        last = busy & done;
    end

endmodule

// File: rtl/lc3_seq_ctrl.sv
// LC-3 instruction sequencer: fetch, decode and execute control for the datapath.
// All controls are decoded from the current state; the only exception is the
// read-data load, which follows the timer so it can track the ready handshake.
module lc3_seq_ctrl
    import lc3_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT    = 2,
    parameter bit          USE_RDY     = 1'b0,
    parameter bit          PAUSE_FETCH = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    input  logic       Mem_Rdy,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    state_t state_q, state_d;
    logic   acc_start, acc_busy, acc_last, acc_done;

    // Timer is preloaded on the edge that enters an access state.
    assign acc_busy  = is_mem_access(state_q);
    assign acc_start = is_mem_access(state_d) && !acc_busy;

    mem_wait_timer #(
        .MEM_WAIT (MEM_WAIT),
        .USE_RDY  (USE_RDY)
    ) u_wait (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (acc_start),
        .busy    (acc_busy),
        .Mem_Rdy (Mem_Rdy),
        .last    (acc_last),
        .done    (acc_done)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_HALTED;
        else          state_q <= state_d;
    end

    // Next-state: fetch/decode sequence and per-opcode execute paths.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HALTED: if (Run) state_d = S_FETCH;
            S_FETCH:  state_d = S_RD_F;
            S_RD_F:   if (acc_done) state_d = S_IR_LD;
            S_IR_LD:  state_d = PAUSE_FETCH ? S_PAUSE1 : S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_ADD:           state_d = S_ADD;
                    OP_AND:           state_d = S_AND;
                    OP_NOT:           state_d = S_NOT;
                    OP_BR:            state_d = BEN ? S_BR_TAKE : S_FETCH;
                    OP_JMP:           state_d = S_JMP;
                    OP_JSR:           state_d = S_JSR_R7;
                    OP_LDR, OP_STR:   state_d = S_MAR_BASE;
                    OP_LD, OP_ST:     state_d = S_MAR_PC;
                    OP_LEA:           state_d = S_LEA;
                    OP_PAUSE:         state_d = S_PAUSE;
                    default:          state_d = S_FETCH;
                endcase
            end
            // JSRR reuses the JMP state: both load PC from SR1 through the adder.
            S_JSR_R7: state_d = IR_11 ? S_JSR_OFF : S_JMP;
            // Opcode bit 0 separates the stores (ST/STR) from the loads (LD/LDR).
            S_MAR_BASE, S_MAR_PC: state_d = Opcode[0] ? S_ST_MDR : S_RD_D;
            S_RD_D:   if (acc_done) state_d = S_LD_WB;
            S_ST_MDR: state_d = S_WR_D;
            S_WR_D:   if (acc_done) state_d = S_FETCH;
            S_PAUSE:  state_d = S_PAUSE1;
            S_PAUSE1: if (Continue) state_d = S_PAUSE2;
            S_PAUSE2: if (!Continue) state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Datapath control decode; everything idles low unless the state drives it.
    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = PCMUX_INC; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
        ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_ZERO; ALUK = ALUK_ADD;
        Mem_OE = 1'b0; Mem_WE = 1'b0;
        unique case (state_q)
            S_FETCH:    begin LD_MAR = 1'b1; LD_PC = 1'b1; GatePC = 1'b1; PCMUX = PCMUX_INC; end
            S_RD_F,
            S_RD_D:     begin Mem_OE = 1'b1; LD_MDR = acc_last; end
            S_IR_LD:    begin LD_IR = 1'b1; GateMDR = 1'b1; end
            S_DECODE:   LD_BEN = 1'b1;
            S_ADD:      begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR1MUX = 1'b1;
                              SR2MUX = IR_5; ALUK = ALUK_ADD; end
            S_AND:      begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR1MUX = 1'b1;
                              SR2MUX = IR_5; ALUK = ALUK_AND; end
            S_NOT:      begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR1MUX = 1'b1;
                              ALUK = ALUK_NOT; end
            S_BR_TAKE:  begin LD_PC = 1'b1; PCMUX = PCMUX_ADDER; ADDR2MUX = ADDR2_OFF9; end
            S_JMP:      begin LD_PC = 1'b1; PCMUX = PCMUX_ADDER; ADDR1MUX = 1'b1;
                              ADDR2MUX = ADDR2_ZERO; SR1MUX = 1'b1; end
            S_JSR_R7:   begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
            S_JSR_OFF:  begin LD_PC = 1'b1; PCMUX = PCMUX_ADDER; ADDR2MUX = ADDR2_OFF11; end
            S_MAR_BASE: begin LD_MAR = 1'b1; GateMARMUX = 1'b1; ADDR1MUX = 1'b1;
                              SR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF6; end
            S_MAR_PC:   begin LD_MAR = 1'b1; GateMARMUX = 1'b1; ADDR2MUX = ADDR2_OFF9; end
            S_LD_WB:    begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
            S_ST_MDR:   begin LD_MDR = 1'b1; GateALU = 1'b1; ALUK = ALUK_PASSA; end
            S_WR_D:     Mem_WE = 1'b1;
            S_LEA:      begin GateMARMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                              ADDR2MUX = ADDR2_OFF9; end
            S_PAUSE:    LD_LED = 1'b1;
            default:    ;
        endcase
    end

endmodule
